// File: rtl/flight_mode_ctrl_pkg.sv
// Shared encodings for the flight mode controller: state codes, debounced
// switch positions and the per-state data-select pattern.
package flight_mode_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_STASIS      = 3'd0,
        ST_USER_IMU    = 3'd1,
        ST_USER_NO_IMU = 3'd2,
        ST_TAKE_OFF    = 3'd3,
        ST_HOVER       = 3'd4,
        ST_AUTO_LAND   = 3'd5,
        ST_FAULT       = 3'd6
    } state_t;

    typedef enum logic [3:0] {
        POS_0X      = 4'h0,
        POS_10      = 4'h1,
        POS_20      = 4'h2,
        POS_11      = 4'h3,
        POS_21      = 4'h4,
        POS_INVALID = 4'hF
    } pos_t;

    localparam logic [1:0] IMU_SEL_ON       = 2'd0;
    localparam logic [1:0] IMU_SEL_OFF      = 2'd1;
    localparam logic [2:0] REC_SEL_IDLE     = 3'd0;
    localparam logic [2:0] REC_SEL_USER     = 3'd1;
    localparam logic [2:0] REC_SEL_TAKE_OFF = 3'd2;
    localparam logic [2:0] REC_SEL_HOVER    = 3'd3;
    localparam logic [2:0] REC_SEL_LAND     = 3'd4;

    localparam logic [7:0] CALIB_DONE = 8'hFF;

    // {imu_data_sel, rec_data_sel} for a given state; unknown codes look like FAULT
    function automatic logic [4:0] sel_for_state(input state_t s);
        case (s)
            ST_STASIS:      return {IMU_SEL_ON,  REC_SEL_IDLE};
            ST_USER_IMU:    return {IMU_SEL_ON,  REC_SEL_USER};
            ST_USER_NO_IMU: return {IMU_SEL_OFF, REC_SEL_USER};
            ST_TAKE_OFF:    return {IMU_SEL_ON,  REC_SEL_TAKE_OFF};
            ST_HOVER:       return {IMU_SEL_ON,  REC_SEL_HOVER};
            ST_AUTO_LAND:   return {IMU_SEL_ON,  REC_SEL_LAND};
            default:        return {IMU_SEL_OFF, REC_SEL_IDLE};
        endcase
    endfunction

endpackage

// File: rtl/flight_mode_ctrl_switch_debounce.sv
// Decodes the receiver switch channel into a position and only accepts a new
// position after it has been seen unchanged for DEBOUNCE_CYCLES cycles.
module switch_debounce
    import flight_mode_ctrl_pkg::*;
#(
    parameter int REC_W           = 8,
    parameter int DEBOUNCE_CYCLES = 1000
) (
    input  logic             us_clk,
    input  logic             reset,
    input  logic             sys_rdy,
    input  logic [REC_W-1:0] swa_swb_val,
    output pos_t             debounced_pos
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    pos_t             raw_pos;
    pos_t             cand_pos;
    logic [CNT_W-1:0] stable_cnt;

    function automatic logic in_band(input logic [REC_W-1:0] v, input int lo, input int hi);
        return (v >= REC_W'(lo)) && (v <= REC_W'(hi));
    endfunction

    // Raw position from the receiver value bands (bounds inclusive)
    always_comb begin
        raw_pos = POS_INVALID;
        if      (in_band(swa_swb_val, 118, 128)) raw_pos = POS_0X;
        else if (in_band(swa_swb_val, 220, 230)) raw_pos = POS_10;
        else if (in_band(swa_swb_val,  18,  28)) raw_pos = POS_20;
        else if (in_band(swa_swb_val, 168, 178)) raw_pos = POS_11;
        else if (in_band(swa_swb_val,  68,  78)) raw_pos = POS_21;
    end

    // Down-counter per candidate; the position is accepted at terminal count.
    // Invalid readings drop the candidate but leave the accepted position alone.
    always_ff @(posedge us_clk) begin
        if (reset || !sys_rdy) begin
            debounced_pos <= POS_0X;
            cand_pos      <= POS_INVALID;
            stable_cnt    <= '0;
        end else if (raw_pos == POS_INVALID) begin
            cand_pos   <= POS_INVALID;
            stable_cnt <= '0;
        end else if (raw_pos != cand_pos) begin
            cand_pos   <= raw_pos;
            stable_cnt <= CNT_W'(DEBOUNCE_CYCLES - 1);
            if (DEBOUNCE_CYCLES == 1) debounced_pos <= raw_pos;
        end else if (stable_cnt != '0) begin
            stable_cnt <= stable_cnt - CNT_W'(1);
            if (stable_cnt == CNT_W'(1)) debounced_pos <= cand_pos;
        end
    end

endmodule

// File: rtl/flight_mode_ctrl.sv
// Flight mode sequencer: power-up gating, motor rate averaging and the
// operator/autonomous mode state machine with data-path select outputs.
//
// state          | meaning
// ST_STASIS      | on the ground, waiting for arm with low throttle
// ST_USER_IMU    | pilot flight, IMU-assisted
// ST_USER_NO_IMU | pilot flight, raw receiver
// ST_TAKE_OFF    | climbing to hover rate
// ST_HOVER       | holding hover
// ST_AUTO_LAND   | descending under land timer
// ST_FAULT       | locked out until reset
module flight_mode_ctrl
    import flight_mode_ctrl_pkg::*;
#(
    parameter int NUM_MOTORS      = 4,
    parameter int RATE_W          = 8,
    parameter int REC_W           = 8,
    parameter int INIT_CYCLES     = 1000000,
    parameter int DEBOUNCE_CYCLES = 1000,
    parameter int LAND_TIMEOUT    = 5000000,
    parameter int MOTOR_MIN       = 10,
    parameter int HOVER_RATE      = 100
) (
    input  logic                         us_clk,
    input  logic                         reset,
    input  logic [NUM_MOTORS*RATE_W-1:0] motor_rates,
    input  logic [REC_W-1:0]             swa_swb_val,
    input  logic [REC_W-1:0]             throttle_val,
    input  logic [7:0]                   imu_calib_status,
    output logic [RATE_W-1:0]            avg_motor_rate,
    output logic [2:0]                   mode,
    output logic [1:0]                   imu_data_sel,
    output logic [2:0]                   rec_data_sel,
    output logic                         sys_rdy,
    output logic                         err_flag,
    output logic [15:0]                  debug_leds
);

    localparam int SHIFT  = $clog2(NUM_MOTORS);
    localparam int SUM_W  = RATE_W + SHIFT;
    localparam int INIT_W = $clog2(INIT_CYCLES + 1);
    localparam int LAND_W = $clog2(LAND_TIMEOUT + 1);
    localparam int CMP_W  = (REC_W > RATE_W) ? REC_W : RATE_W;
    localparam int NIB_SH = (INIT_W > 4) ? INIT_W - 4 : 0;

    state_t              state, state_next;
    logic                bad_state;
    pos_t                debounced_pos;
    logic [SUM_W-1:0]    rate_sum;
    logic [INIT_W-1:0]   init_cnt;
    logic [LAND_W-1:0]   land_cnt;
    logic [3:0]          init_nib;
    logic                airborne, at_hover, thr_low, thr_ge_hover, thr_ge_avg;

    switch_debounce #(
        .REC_W           (REC_W),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_switch_debounce (
        .us_clk        (us_clk),
        .reset         (reset),
        .sys_rdy       (sys_rdy),
        .swa_swb_val   (swa_swb_val),
        .debounced_pos (debounced_pos)
    );

    // Sum is widened by log2(NUM_MOTORS) so the all-ones case cannot wrap
    always_comb begin
        rate_sum = '0;
        for (int i = 0; i < NUM_MOTORS; i++)
            rate_sum = rate_sum + SUM_W'(motor_rates[i*RATE_W +: RATE_W]);
    end

    // Registered average
    always_ff @(posedge us_clk) begin
        if (reset) avg_motor_rate <= '0;
        else       avg_motor_rate <= rate_sum[SUM_W-1:SHIFT];
    end

    // Power-up settle timer; ready latches once settled and the IMU is calibrated
    always_ff @(posedge us_clk) begin
        if (reset) begin
            init_cnt <= INIT_W'(INIT_CYCLES);
            sys_rdy  <= 1'b0;
        end else begin
            if (init_cnt != '0) init_cnt <= init_cnt - INIT_W'(1);
            if (init_cnt == '0 && imu_calib_status == CALIB_DONE) sys_rdy <= 1'b1;
        end
    end

    assign airborne     = avg_motor_rate > RATE_W'(MOTOR_MIN);
    assign at_hover     = avg_motor_rate >= RATE_W'(HOVER_RATE);
    assign thr_low      = throttle_val <= REC_W'(MOTOR_MIN);
    assign thr_ge_hover = throttle_val >= REC_W'(HOVER_RATE);
    assign thr_ge_avg   = CMP_W'(throttle_val) >= CMP_W'(avg_motor_rate);
    assign init_nib     = 4'(init_cnt >> NIB_SH);
    assign mode         = state;

    // Next-state decode
    always_comb begin
        state_next = state;
        bad_state  = 1'b0;
        if (!sys_rdy) begin
            state_next = ST_STASIS;
        end else begin
            case (state)
                ST_STASIS: begin
                    if (debounced_pos == POS_10 && thr_low)      state_next = ST_USER_IMU;
                    else if (debounced_pos == POS_11 && thr_low) state_next = ST_USER_NO_IMU;
                end
                ST_USER_IMU: begin
                    if (debounced_pos == POS_11)      state_next = ST_USER_NO_IMU;
                    else if (debounced_pos == POS_20) state_next = airborne ? ST_HOVER : ST_TAKE_OFF;
                    else if (debounced_pos == POS_0X) state_next = airborne ? ST_AUTO_LAND : ST_STASIS;
                end
                ST_USER_NO_IMU: begin
                    if (debounced_pos == POS_10)      state_next = ST_USER_IMU;
                    else if (debounced_pos == POS_21) state_next = airborne ? ST_HOVER : ST_TAKE_OFF;
                    else if (debounced_pos == POS_0X) state_next = airborne ? ST_AUTO_LAND : ST_STASIS;
                end
                ST_TAKE_OFF: begin
                    if (at_hover)                                   state_next = ST_HOVER;
                    else if (debounced_pos == POS_0X)               state_next = airborne ? ST_AUTO_LAND : ST_STASIS;
                    else if (debounced_pos == POS_10 && thr_ge_avg) state_next = ST_USER_IMU;
                    else if (debounced_pos == POS_11 && thr_ge_avg) state_next = ST_USER_NO_IMU;
                end
                ST_HOVER: begin
                    if (debounced_pos == POS_0X)                      state_next = ST_AUTO_LAND;
                    else if (debounced_pos == POS_10 && thr_ge_hover) state_next = ST_USER_IMU;
                    else if (debounced_pos == POS_11 && thr_ge_hover) state_next = ST_USER_NO_IMU;
                end
                ST_AUTO_LAND: begin
                    if (!airborne)                                  state_next = ST_STASIS;
                    else if (land_cnt == '0)                        state_next = ST_FAULT;
                    else if (debounced_pos == POS_10 && thr_ge_avg) state_next = ST_USER_IMU;
                    else if (debounced_pos == POS_11 && thr_ge_avg) state_next = ST_USER_NO_IMU;
                end
                ST_FAULT: state_next = ST_FAULT;
                default: begin
                    state_next = ST_FAULT;
                    bad_state  = 1'b1;
                end
            endcase
        end
    end

    // State and Moore outputs, all registered from the next state
    always_ff @(posedge us_clk) begin
        if (reset) begin
            state        <= ST_STASIS;
            imu_data_sel <= '0;
            rec_data_sel <= '0;
            err_flag     <= 1'b0;
        end else begin
            state                        <= state_next;
            {imu_data_sel, rec_data_sel} <= sel_for_state(state_next);
            err_flag                     <= err_flag | bad_state | (state_next == ST_FAULT);
        end
    end

    // Land timer: loaded on each entry to AUTO_LAND, expires at zero
    always_ff @(posedge us_clk) begin
        if (reset)
            land_cnt <= LAND_W'(LAND_TIMEOUT - 1);
        else if (state_next == ST_AUTO_LAND && state != ST_AUTO_LAND)
            land_cnt <= LAND_W'(LAND_TIMEOUT - 1);
        else if (state == ST_AUTO_LAND && land_cnt != '0)
            land_cnt <= land_cnt - LAND_W'(1);
    end

    // Status LEDs: live status when ready, a walking bit for init progress otherwise
    always_ff @(posedge us_clk) begin
        if (reset)        debug_leds <= '0;
        else if (sys_rdy) debug_leds <= {err_flag, sys_rdy, debounced_pos, 7'b0, state};
        else              debug_leds <= 16'h8000 >> init_nib;
    end

endmodule

// File: tb/tb_flight_mode_ctrl.sv
// Self-checking bench for flight_mode_ctrl with short timers.
module tb_flight_mode_ctrl;
    import flight_mode_ctrl_pkg::*;

    logic        us_clk = 1'b0;
    logic        reset;
    logic [31:0] motor_rates;
    logic [63:0] motor_rates8;
    logic [7:0]  swa, throttle, calib;

    logic [7:0]  avg, avg8;
    logic [2:0]  mode, mode8;
    logic [1:0]  imu_sel, imu_sel8;
    logic [2:0]  rec_sel, rec_sel8;
    logic        sys_rdy, sys_rdy8, err_flag, err_flag8;
    logic [15:0] leds, leds8;

    int total = 0;
    int bad   = 0;

    logic [2:0] mode_q[$];
    logic [7:0] avg_q[$];
    logic [7:0] avg8_q[$];
    logic       rdy_q[$];

    always #5 us_clk = ~us_clk;

    flight_mode_ctrl #(.NUM_MOTORS(4), .INIT_CYCLES(16), .DEBOUNCE_CYCLES(4), .LAND_TIMEOUT(64)) dut (
        .us_clk(us_clk), .reset(reset), .motor_rates(motor_rates), .swa_swb_val(swa),
        .throttle_val(throttle), .imu_calib_status(calib), .avg_motor_rate(avg), .mode(mode),
        .imu_data_sel(imu_sel), .rec_data_sel(rec_sel), .sys_rdy(sys_rdy), .err_flag(err_flag),
        .debug_leds(leds));

    flight_mode_ctrl #(.NUM_MOTORS(8), .INIT_CYCLES(16), .DEBOUNCE_CYCLES(4), .LAND_TIMEOUT(64)) dut8 (
        .us_clk(us_clk), .reset(reset), .motor_rates(motor_rates8), .swa_swb_val(swa),
        .throttle_val(throttle), .imu_calib_status(calib), .avg_motor_rate(avg8), .mode(mode8),
        .imu_data_sel(imu_sel8), .rec_data_sel(rec_sel8), .sys_rdy(sys_rdy8), .err_flag(err_flag8),
        .debug_leds(leds8));

    task automatic tick();
        @(posedge us_clk);
        @(negedge us_clk);
    endtask

    task automatic test_reset();
        reset = 1'b1; calib = 8'h00; swa = 8'd0; throttle = 8'd0;
        motor_rates = {4{8'd77}}; motor_rates8 = {8{8'd77}};
        repeat (3) tick();
        total++; if (mode !== 3'd0)      begin bad++; $display("FAIL reset_mode: got %0d expected 0", mode); end
        total++; if (avg !== 8'd0)       begin bad++; $display("FAIL reset_avg: got %0d expected 0", avg); end
        total++; if (imu_sel !== 2'd0)   begin bad++; $display("FAIL reset_imu_sel: got %0d expected 0", imu_sel); end
        total++; if (rec_sel !== 3'd0)   begin bad++; $display("FAIL reset_rec_sel: got %0d expected 0", rec_sel); end
        total++; if (sys_rdy !== 1'b0)   begin bad++; $display("FAIL reset_sys_rdy: got %0d expected 0", sys_rdy); end
        total++; if (err_flag !== 1'b0)  begin bad++; $display("FAIL reset_err: got %0d expected 0", err_flag); end
        total++; if (leds !== 16'h0000)  begin bad++; $display("FAIL reset_leds: got %h expected 0000", leds); end
    endtask

    task automatic test_average();
        logic [31:0] pat4 [4] = '{ {8'd41, 8'd30, 8'd20, 8'd10}, {4{8'hFF}},
                                   {8'd3, 8'd0, 8'd0, 8'd0},     {8'd200, 8'd100, 8'd7, 8'd1} };
        logic [7:0]  exp4 [4] = '{ 8'd25, 8'd255, 8'd0, 8'd77 };
        logic [63:0] pat8 [4] = '{ {8{8'hFF}}, {8'd210, 8'd180, 8'd150, 8'd120, 8'd90, 8'd60, 8'd30, 8'd0},
                                   {8{8'h01}}, {8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00} };
        logic [7:0]  exp8 [4] = '{ 8'hFF, 8'd105, 8'd1, 8'd127 };
        logic [7:0]  e;
        reset = 1'b0;
        motor_rates = 32'd0; motor_rates8 = 64'd0;
        tick();
        for (int i = 0; i < 4; i++) begin
            motor_rates = pat4[i]; motor_rates8 = pat8[i];
            avg_q.push_back(exp4[i]); avg8_q.push_back(exp8[i]);
            if (i == 0) begin
                #1;
                total++; if (avg !== 8'd0) begin bad++; $display("FAIL avg_latency: got %0d expected 0", avg); end
            end
            tick();
            e = avg_q.pop_front();
            total++; if (avg !== e) begin bad++; $display("FAIL avg4_%0d: got %0d expected %0d", i, avg, e); end
            e = avg8_q.pop_front();
            total++; if (avg8 !== e) begin bad++; $display("FAIL avg8_%0d: got %0d expected %0d", i, avg8, e); end
        end
        motor_rates = 32'd0; motor_rates8 = 64'd0;
    endtask

    task automatic test_init_gating();
        logic e;
        reset = 1'b1; calib = 8'h00;
        tick();
        reset = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            rdy_q.push_back(1'b0);
            tick();
            e = rdy_q.pop_front();
            total++; if (sys_rdy !== e) begin bad++; $display("FAIL init_calib_low_c%0d: got %0d expected %0d", c, sys_rdy, e); end
        end
        total++; if (leds === 16'h0000) begin bad++; $display("FAIL init_leds: got %h expected nonzero", leds); end
        calib = 8'hFF;
        rdy_q.push_back(1'b1);
        tick();
        e = rdy_q.pop_front();
        total++; if (sys_rdy !== e) begin bad++; $display("FAIL init_calib_rise: got %0d expected %0d", sys_rdy, e); end
    endtask

    task automatic test_init_min_time();
        logic e;
        reset = 1'b1; calib = 8'hFF;
        tick();
        reset = 1'b0;
        for (int c = 1; c <= 17; c++) begin
            rdy_q.push_back(c == 17);
            tick();
            e = rdy_q.pop_front();
            total++; if (sys_rdy !== e) begin bad++; $display("FAIL init_min_c%0d: got %0d expected %0d", c, sys_rdy, e); end
        end
    endtask

    task automatic test_debounce();
        logic [7:0] seq [9] = '{8'd223, 8'd223, 8'd223, 8'd20, 8'd223, 8'd223, 8'd223, 8'd223, 8'd223};
        logic [2:0] e;
        throttle = 8'd0; motor_rates = 32'd0;
        for (int i = 0; i < 9; i++) begin
            swa = seq[i];
            mode_q.push_back(i == 8 ? 3'(ST_USER_IMU) : 3'(ST_STASIS));
            tick();
            e = mode_q.pop_front();
            total++; if (mode !== e) begin bad++; $display("FAIL debounce_mode_c%0d: got %0d expected %0d", i + 1, mode, e); end
        end
        total++; if (rec_sel !== 3'd1) begin bad++; $display("FAIL debounce_rec_sel: got %0d expected 1", rec_sel); end
        total++; if (imu_sel !== 2'd0) begin bad++; $display("FAIL debounce_imu_sel: got %0d expected 0", imu_sel); end
        tick();
        total++; if (leds !== 16'h4401) begin bad++; $display("FAIL debounce_leds: got %h expected 4401", leds); end
    endtask

    task automatic test_takeoff_hover();
        logic [7:0] m_avg, prev, ea;
        logic [2:0] m_mode, em;
        swa = 8'd23;
        for (int i = 1; i <= 5; i++) begin
            mode_q.push_back(i == 5 ? 3'(ST_TAKE_OFF) : 3'(ST_USER_IMU));
            tick();
            em = mode_q.pop_front();
            total++; if (mode !== em) begin bad++; $display("FAIL takeoff_entry_c%0d: got %0d expected %0d", i, mode, em); end
        end
        total++; if (rec_sel !== 3'd2) begin bad++; $display("FAIL takeoff_rec_sel: got %0d expected 2", rec_sel); end
        m_avg = 8'd0; m_mode = ST_TAKE_OFF;
        for (int k = 0; k <= 12; k++) begin
            prev  = m_avg;
            m_avg = 8'(k * 10);
            if (m_mode == ST_TAKE_OFF && prev >= 8'd100) m_mode = ST_HOVER;
            motor_rates = {4{m_avg}};
            mode_q.push_back(m_mode); avg_q.push_back(m_avg);
            tick();
            em = mode_q.pop_front(); ea = avg_q.pop_front();
            total++; if (mode !== em) begin bad++; $display("FAIL ramp_mode_k%0d: got %0d expected %0d", k, mode, em); end
            total++; if (avg !== ea)  begin bad++; $display("FAIL ramp_avg_k%0d: got %0d expected %0d", k, avg, ea); end
        end
        total++; if (rec_sel !== 3'd3) begin bad++; $display("FAIL hover_rec_sel: got %0d expected 3", rec_sel); end
    endtask

    task automatic test_reset_midflight();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        total++; if (mode !== 3'd0)     begin bad++; $display("FAIL midreset_mode: got %0d expected 0", mode); end
        total++; if (sys_rdy !== 1'b0)  begin bad++; $display("FAIL midreset_sys_rdy: got %0d expected 0", sys_rdy); end
        total++; if (err_flag !== 1'b0) begin bad++; $display("FAIL midreset_err: got %0d expected 0", err_flag); end
        total++; if (avg !== 8'd0)      begin bad++; $display("FAIL midreset_avg: got %0d expected 0", avg); end
        total++; if (rec_sel !== 3'd0)  begin bad++; $display("FAIL midreset_rec_sel: got %0d expected 0", rec_sel); end
    endtask

    task automatic test_land_timeout();
        int         waited;
        logic [2:0] em;
        calib = 8'hFF; throttle = 8'd0; motor_rates = {4{8'd50}}; swa = 8'd223;
        waited = 0;
        while (sys_rdy !== 1'b1 && waited < 40) begin tick(); waited++; end
        total++; if (sys_rdy !== 1'b1) begin bad++; $display("FAIL land_bringup_timeout: got %0d expected 1", sys_rdy); end
        repeat (6) tick();
        total++; if (mode !== 3'(ST_USER_IMU)) begin bad++; $display("FAIL land_arm: got %0d expected 1", mode); end
        swa = 8'd23;
        repeat (6) tick();
        total++; if (mode !== 3'(ST_HOVER)) begin bad++; $display("FAIL land_hover: got %0d expected 4", mode); end
        swa = 8'd123;
        for (int j = 1; j <= 69; j++) begin
            mode_q.push_back(j < 5 ? 3'(ST_HOVER) : (j < 69 ? 3'(ST_AUTO_LAND) : 3'(ST_FAULT)));
            tick();
            em = mode_q.pop_front();
            total++; if (mode !== em) begin bad++; $display("FAIL land_mode_c%0d: got %0d expected %0d", j, mode, em); end
        end
        total++; if (err_flag !== 1'b1) begin bad++; $display("FAIL fault_err: got %0d expected 1", err_flag); end
        total++; if (imu_sel !== 2'd1)  begin bad++; $display("FAIL fault_imu_sel: got %0d expected 1", imu_sel); end
        total++; if (rec_sel !== 3'd0)  begin bad++; $display("FAIL fault_rec_sel: got %0d expected 0", rec_sel); end
        swa = 8'd223; throttle = 8'd200;
        for (int j = 1; j <= 10; j++) begin
            mode_q.push_back(3'(ST_FAULT));
            tick();
            em = mode_q.pop_front();
            total++; if (mode !== em) begin bad++; $display("FAIL fault_hold_c%0d: got %0d expected %0d", j, mode, em); end
        end
        total++; if (err_flag !== 1'b1) begin bad++; $display("FAIL fault_err_sticky: got %0d expected 1", err_flag); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1; motor_rates = '0; motor_rates8 = '0;
        swa = '0; throttle = '0; calib = '0;
        @(negedge us_clk);
        test_reset();
        test_average();
        test_init_gating();
        test_init_min_time();
        test_debounce();
        test_takeoff_hover();
        test_reset_midflight();
        test_land_timeout();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
